dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Sequences the single-port data block RAM and shares it between two requesters: the CPU load/store port (port C) and a debug/loader DMA port (port D).
- Performs address range/alignment checks, sub-word read formatting with sign extension, and read-modify-write for byte/halfword stores.
- Drives a RAM with 1-cycle registered read latency; generates the CPU stall.

Parameters:
- DEPTH, 1024, data RAM depth in 32-bit words (power of two).
- AW, 10, RAM word-address width, log2(DEPTH).
- BASE_ADDR, 32'h1000, byte address mapped to RAM word 0.
- STARVE_LIMIT, 4, consecutive CPU grants while D waits before D is forced.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- c_req  in  1  CPU request; held, with all c_* fields stable, until c_ack.
- c_we  in  1  1 = store, 0 = load.
- c_addr  in  32  byte address.
- c_wdata  in  32  store data, right-aligned.
- c_size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
- c_signed  in  1  sign-extend sub-word loads.
- c_rdata  out  32  load result; valid at c_ack, held until the next c_ack.
- c_ack  out  1  one-cycle completion pulse.
- c_err  out  1  valid with c_ack: access was out of range or misaligned.
- d_req  in  1  DMA request; word-only; same hold rule as c_req.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load result; valid at d_ack, held until the next d_ack.
- d_ack  out  1  one-cycle completion pulse.
- d_err  out  1  valid with d_ack.
- stall  out  1  c_req & ~c_ack, combinational.
- mem_addr  out  AW  RAM word address.
- mem_re  out  1  RAM read enable.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  32  RAM write word.
- mem_rdata  in  32  RAM read data, valid the cycle after mem_re.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = IDLE; c_ack = d_ack = c_err = d_err = 0.
  - c_rdata = d_rdata = 0; starve_cnt = 0.
  - mem_re = mem_we = 0 immediately; mem_addr and mem_wdata = 0.
  - Reset mid-transaction abandons it with no partial RAM write and no ack.
- mem_* outputs are combinational from state and the latched request registers.
- Arbitration occurs in IDLE only.
  - Winner is C if c_req, unless d_req and starve_cnt == STARVE_LIMIT, in which case D wins.
  - The winner's fields are latched and the grant port is recorded.
  - Requests arriving while the block is busy wait in IDLE.
- starve_cnt:
  - +1 on each C grant while d_req = 1.
  - Cleared on a D grant, or in any cycle where d_req = 0.
  - Saturates at STARVE_LIMIT.
- Address decode:
  - offs = addr - BASE_ADDR; word index = offs[AW+1:2].
  - Error if addr < BASE_ADDR or offs >= 4*DEPTH.
  - Error on misalignment: half with addr[0] = 1, or word with addr[1:0] != 0.
  - Error if size = 11.
  - On error: no RAM access; ISSUE goes straight to DONE with err = 1 and rdata = 0.
- FSM states: IDLE -> ISSUE -> {WAIT | DONE}; WAIT -> {DONE | MERGE}; MERGE -> DONE; DONE -> IDLE.
  - ISSUE, word store: mem_we = 1, mem_wdata = wdata, then DONE.
  - ISSUE, load or sub-word store: mem_re = 1, then WAIT.
  - WAIT, load: format mem_rdata into the port's rdata register, then DONE.
  - WAIT, sub-word store: merge into a register, then MERGE.
  - MERGE: mem_we = 1 with the merged word, then DONE.
  - DONE: ack (and err) = 1 for the granted port, one cycle only, then IDLE.
- Latency from the IDLE cycle that samples req to the ack cycle:
  - 2 cycles for a word store.
  - 3 cycles for a load.
  - 4 cycles for a sub-word store.
  - 2 cycles for an error.
  - Back-to-back throughput: one transaction per latency + 1 cycles.
- Byte lanes are little-endian: byte n = bits [8n+7:8n].
- Load formatting:
  - Byte: lane addr[1:0].
  - Half: lanes {2h+1, 2h} with h = addr[1].
  - Zero-extend, or sign-extend from bit 7 (byte) / bit 15 (half) when signed.
- Store merge: only the addressed lane(s) are replaced by wdata[7:0] or wdata[15:0]; all other lanes keep mem_rdata.
- The D port ignores size and signed; it is always a word access.

Test Plan:
- Word store C addr 0x1004 data 0xDEADBEEF, then load word 0x1004 -> ack 2 cycles after store sample; load c_rdata = 0xDEADBEEF, c_err = 0, c_ack 3 cycles after sample.
- RAM word 1 = 0x11223344; byte store 0xAA at 0x1006 -> RAM word 1 = 0x11AA3344; signed byte load 0x1006 -> 0xFFFFFFAA; unsigned half load 0x1006 -> 0x000011AA.
- Errors: load 0x0FFC, half load 0x1001, word store 0x1000 + 4*DEPTH -> each c_ack + c_err 2 cycles after sample, c_rdata = 0, mem_we never asserted.
- c_req and d_req both held continuously with STARVE_LIMIT = 4 -> grant order C,C,C,C,D,C,C,C,C,D; stall high exactly while c_req & ~c_ack.
- rst_n low during MERGE of a byte store -> mem_we drops immediately, target word unchanged, no ack, state IDLE after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data RAM sequencer shared by the CPU load/store port (C) and a debug/loader DMA port (D).
// Handles range/alignment checks, sub-word load formatting and read-modify-write sub-word stores.
module dmem_arbiter #(
  parameter int          DEPTH        = 1024,
  parameter int          AW           = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h1000,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [31:0]   c_addr,
  input  logic [31:0]   c_wdata,
  input  logic [1:0]    c_size,
  input  logic          c_signed,
  output logic [31:0]   c_rdata,
  output logic          c_ack,
  output logic          c_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ack,
  output logic          d_err,
  output logic          stall,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int              SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [31:0]     SPAN       = 32'(4 * DEPTH);
  localparam logic [1:0]      SZ_BYTE    = 2'b00;
  localparam logic [1:0]      SZ_HALF    = 2'b01;
  localparam logic [1:0]      SZ_WORD    = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_MERGE, S_DONE} state_e;

  state_e        state_q, state_d;
  logic          gnt_d_q, gnt_d_d;   // 1 = current transaction belongs to port D
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic          sgn_q, sgn_d;
  logic [31:0]   merge_q, merge_d;
  logic [31:0]   c_rdata_q, c_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          c_ack_q, c_ack_d, c_err_q, c_err_d;
  logic          d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [SW-1:0] starve_q, starve_d;

  logic [31:0]   offs;
  logic [AW-1:0] widx;
  logic          acc_err, word_store;
  logic          finish, fin_err;

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_BYTE: return {{24{sg & b[7]}}, b};
      SZ_HALF: return {{16{sg & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] w, input logic [15:0] wd,
                                             input logic [1:0] a, input logic [1:0] sz);
    logic [31:0] m;
    m = w;
    if (sz == SZ_BYTE)  m[{a, 3'b000} +: 8] = wd[7:0];
    else if (a[1])      m[31:16] = wd;
    else                m[15:0]  = wd;
    return m;
  endfunction

  // Decode works on the latched request, so it is stable for the whole transaction.
  always_comb begin
    offs       = addr_q - BASE_ADDR;
    widx       = offs[AW+1:2];
    acc_err    = (addr_q < BASE_ADDR) || (offs >= SPAN) || (size_q == 2'b11) ||
                 ((size_q == SZ_HALF) && addr_q[0]) ||
                 ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
    word_store = we_q && (size_q == SZ_WORD);
  end

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
    state_d   = state_q;
    gnt_d_d   = gnt_d_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    merge_d   = merge_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    c_ack_d   = 1'b0;
    c_err_d   = 1'b0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    starve_d  = d_req ? starve_q : '0;
    finish    = 1'b0;
    fin_err   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (c_req && !(d_req && (starve_q == STARVE_MAX))) begin
          gnt_d_d = 1'b0;
          we_d    = c_we;
          addr_d  = c_addr;
          wdata_d = c_wdata;
          size_d  = c_size;
          sgn_d   = c_signed;
          state_d = S_ISSUE;
          if (d_req && (starve_q != STARVE_MAX)) starve_d = starve_q + 1'b1;
        end else if (d_req) begin
          gnt_d_d  = 1'b1;
          we_d     = d_we;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          size_d   = SZ_WORD;
          sgn_d    = 1'b0;
          state_d  = S_ISSUE;
          starve_d = '0;
        end
      end
      S_ISSUE: begin
        if (acc_err) begin
          finish  = 1'b1;
          fin_err = 1'b1;
          if (gnt_d_q) d_rdata_d = '0;
          else         c_rdata_d = '0;
        end else if (word_store) begin
          finish = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (we_q) begin
          merge_d = merge_word(mem_rdata, wdata_q[15:0], addr_q[1:0], size_q);
          state_d = S_MERGE;
        end else begin
          finish = 1'b1;
          if (gnt_d_q) d_rdata_d = mem_rdata;
          else         c_rdata_d = fmt_load(mem_rdata, addr_q[1:0], size_q, sgn_q);
        end
      end
      S_MERGE: finish  = 1'b1;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Ack/err are registered so they are high for exactly the DONE cycle.
    if (finish) begin
      state_d = S_DONE;
      if (gnt_d_q) begin
        d_ack_d = 1'b1;
        d_err_d = fin_err;
      end else begin
        c_ack_d = 1'b1;
        c_err_d = fin_err;
      end
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_d_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      sgn_q     <= 1'b0;
      merge_q   <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
      c_ack_q   <= 1'b0;
      c_err_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_d_q   <= gnt_d_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      sgn_q     <= sgn_d;
      merge_q   <= merge_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
      c_ack_q   <= c_ack_d;
      c_err_q   <= c_err_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      starve_q  <= starve_d;
    end
  end

  // RAM strobes come straight from state, so an async reset kills them in the same instant.
  always_comb begin
    mem_re    = (state_q == S_ISSUE) && !acc_err && !word_store;
    mem_we    = ((state_q == S_ISSUE) && !acc_err && word_store) || (state_q == S_MERGE);
    mem_addr  = (((state_q == S_ISSUE) && !acc_err) || (state_q == S_MERGE)) ? widx : '0;
    mem_wdata = '0;
    if ((state_q == S_ISSUE) && word_store) mem_wdata = wdata_q;
    else if (state_q == S_MERGE)            mem_wdata = merge_q;
  end

  assign c_rdata = c_rdata_q;
  assign c_ack   = c_ack_q;
  assign c_err   = c_err_q;
  assign d_rdata = d_rdata_q;
  assign d_ack   = d_ack_q;
  assign d_err   = d_err_q;
  assign stall   = c_req & ~c_ack_q;

endmodule
